// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the datapath and the data-memory stage
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_stage.sv
// data_mem_stage: multi-cycle load/store stage over a word-organised RAM with byte-lane
// writes and sign/zero-extended loads; one response pulse per accepted request.
module data_mem_stage #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input logic       clk,
    input logic       rst_n,
    data_mem_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic we_q, uns_q;
    logic [1:0] size_q;
    logic [31:0] addr_q, wdata_q;
    logic we, uns;
    logic [1:0] size, lane;
    logic [31:0] addr, wdata;
    logic accept, commit, err;
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0] be;
    logic [31:0] wlanes, word, shifted, ext, rdata_q;
    logic err_q;
    logic [31:0] mem [2**DEPTH_LOG2];
    assign bus.req_ready = state == S_IDLE;
    assign bus.rsp_valid = state == S_RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign accept = bus.req_valid && bus.req_ready;
    // With zero wait cycles the commit edge is the accept edge, so the live request is used there
    assign we    = (state == S_IDLE) ? bus.req_we       : we_q;
    assign uns   = (state == S_IDLE) ? bus.req_unsigned : uns_q;
    assign size  = (state == S_IDLE) ? bus.req_size     : size_q;
    assign addr  = (state == S_IDLE) ? bus.req_addr     : addr_q;
    assign wdata = (state == S_IDLE) ? bus.req_wdata    : wdata_q;
    assign idx  = addr[DEPTH_LOG2+1:2];
    assign lane = addr[1:0];
    assign err  = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && lane != 2'd0)
                  || addr[31:DEPTH_LOG2+2] != '0;
    assign be     = size == 2'd0 ? 4'b0001 << lane : size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlanes = size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
    assign word    = mem[idx];
    assign shifted = word >> {lane, 3'b000};
    assign ext = size == 2'd0 ? {{24{!uns && shifted[7]}}, shifted[7:0]}
               : size == 2'd1 ? {{16{!uns && shifted[15]}}, shifted[15:0]} : word;
    assign commit = rst_n && state_nx == S_RESP && state != S_RESP;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: if (accept) begin
                state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                cnt_nx   = '0;
            end
            S_WAIT: if (cnt == 4'(WAIT_CYCLES - 1)) state_nx = S_RESP;
                    else cnt_nx = cnt + 4'd1;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            rdata_q <= (commit && !err && !we) ? ext : '0;
            err_q   <= commit && err;
        end
    end
    always_ff @(posedge clk) begin
        if (commit && we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: table-driven load/store vectors with a response scoreboard,
// plus hand-written back-to-back and mid-request reset sequences.
module tb_data_mem_stage;
    localparam int WC = 2;
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          tag;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t sb[$];
    vec_t tbl[$];
    data_mem_if bus();
    data_mem_stage #(.DEPTH_LOG2(6), .WAIT_CYCLES(WC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("rdata[%0d]", e.tag), bus.rsp_rdata, e.rdata);
                chk($sformatf("err[%0d]", e.tag), {31'd0, bus.rsp_err}, {31'd0, e.err});
                chk($sformatf("latency[%0d]", e.tag), cyc - e.acc, WC);
            end
        end
    end
    task automatic send(input vec_t v, input bit keep, input bit expect_rsp, input int tag, output int acc);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = v.we;
        bus.req_size = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr = v.addr;
        bus.req_wdata = v.wdata;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (!bus.req_ready) begin
            chk($sformatf("accept_timeout[%0d]", tag), 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (expect_rsp) sb.push_back('{v.exp_rdata, v.exp_err, acc, tag});
        @(posedge clk);
        #1 if (!keep) bus.req_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
    endtask
    initial begin
        int acc, prev;
        vec_t v;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        // {we, size, unsigned, addr, wdata, expected rdata, expected err}
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h11,  32'hFFFFFF5A, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h0,   32'h11111111, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h102, 32'h99999999, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'h11111111, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h10,  32'h77777777, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'd2, 1'b1, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h14,  32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h16,  32'hABCD8001, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        32'h80010000, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h16,  32'h0,        32'h00008001, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h16,  32'h0,        32'hFFFF8001, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h16,  32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'hFC,  32'h81020304, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'hFF,  32'h0,        32'hFFFFFF81, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'hFC,  32'h0,        32'h00000004, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0});
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_err", {31'd0, bus.rsp_err}, 32'd0);
        rst_n = 1'b1;
        foreach (tbl[i]) send(tbl[i], 1'b0, 1'b1, i, acc);
        drain();
        // Continuous req_valid: one accept every WC+2 cycles, nothing lost or duplicated
        v = '{1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0};
        send(v, 1'b1, 1'b1, 100, prev);
        v = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0};
        send(v, 1'b1, 1'b1, 101, acc);
        chk("b2b_spacing_1", acc - prev, WC + 2);
        prev = acc;
        v = '{1'b0, 2'd0, 1'b1, 32'h31, 32'h0, 32'h000000A5, 1'b0};
        send(v, 1'b0, 1'b1, 102, acc);
        chk("b2b_spacing_2", acc - prev, WC + 2);
        drain();
        // Reset during WAIT aborts a store before its commit edge
        v = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0};
        send(v, 1'b0, 1'b0, 200, acc);
        @(negedge clk);
        chk("abort_in_wait_ready", {31'd0, bus.req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_rdata", bus.rsp_rdata, 32'd0);
        chk("abort_err", {31'd0, bus.rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        v = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0};
        send(v, 1'b0, 1'b1, 201, acc);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
